program_loader: RTL and testbench

Serial-to-instruction-memory writer: receives a framed byte stream from the UART receiver, assembles big-endian 16-bit instruction words and writes them sequentially into instruction RAM from address 0. CpuHold keeps the multicycle CPU controller (PC and register enables) frozen while a load is in progress. The CPU is the reader of instruction memory; this block is its writer, sitting between the UART receive path and RAM port B.

---
 rtl/loader_pkg.sv | 28 ++
 rtl/program_loader_if.sv | 25 ++
 rtl/loader_timeout.sv | 29 ++
 rtl/program_loader.sv | 129 ++++++++++++
 tb/tb_program_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and frame layout for the serial instruction-memory loader.
// The state encoding and frame offsets are common to the RTL and its bench.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_CNT_HI,
      GET_CNT_LO,
      GET_HI,
      GET_LO,
      GET_CHK,
      DONE,
      ERR
   } state_t;

   localparam int CNT_BYTES = 2;
   localparam int CHK_BYTES = 1;

   // True while a frame is in flight: bytes are accepted and the idle timer runs.
   function automatic logic is_get(state_t s);
      return s inside {GET_CNT_HI, GET_CNT_LO, GET_HI, GET_LO, GET_CHK};
   endfunction

   function automatic int frame_bytes(int n_words);
      return CNT_BYTES + 2 * n_words + CHK_BYTES;
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-RAM write port and CPU status lines of the loader.
// The master modport is the loader itself; slave is the surrounding system.
interface program_loader_if #(
   parameter int AW = 10
);
   logic          Start;
   logic          RxValid;
   logic [7:0]    RxData;
   logic [AW-1:0] MemAddr;
   logic [15:0]   MemData;
   logic          MemWe;
   logic          CpuHold;
   logic          Done;
   logic          Error;

   modport master (
      input  Start, RxValid, RxData,
      output MemAddr, MemData, MemWe, CpuHold, Done, Error
   );

   modport slave (
      output Start, RxValid, RxData,
      input  MemAddr, MemData, MemWe, CpuHold, Done, Error
   );
endinterface

// File: rtl/loader_timeout.sv
// Idle-gap counter: counts enabled cycles, clears on request, and flags the
// cycle in which the TIMEOUT-th consecutive enabled cycle is reached.
module loader_timeout #(
   parameter int TIMEOUT = 50000,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   assign tc_o = en_i && !clr_i && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/program_loader.sv
// Frame parser that assembles big-endian 16-bit words from a UART byte stream
// and writes them sequentially into instruction RAM, holding the CPU meanwhile.
module program_loader
   import loader_pkg::*;
#(
   parameter int AW      = 10,
   parameter int TIMEOUT = 50000
) (
   input logic               Clk,
   input logic               Reset_n,
   program_loader_if.master  bus_io
);

   localparam int          TW    = $clog2(TIMEOUT + 1);
   localparam int          WW    = AW + 1;
   localparam logic [31:0] DEPTH = 32'd1 << AW;

   state_t        state_q, state_d;
   logic [7:0]    cnt_hi_q, cnt_hi_d;
   logic [15:0]   n_q, n_d;
   logic [7:0]    hi_q, hi_d;
   logic [7:0]    xor_q, xor_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          we_q, we_d;

   logic          to_clr, to_en, to_tc;
   logic [15:0]   n_rx;
   logic [WW-1:0] wcnt_inc;

   // Start and any received byte restart the idle gap; outside a frame it is held at zero.
   assign to_clr = bus_io.Start || bus_io.RxValid || !is_get(state_q);
   assign to_en  = !to_clr;

   loader_timeout #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timeout (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .clr_i   (to_clr),
      .en_i    (to_en),
      .tc_o    (to_tc)
   );

   assign n_rx     = {cnt_hi_q, bus_io.RxData};
   assign wcnt_inc = wcnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_hi_d = cnt_hi_q;
      n_d      = n_q;
      hi_d     = hi_q;
      xor_d    = xor_q;
      wcnt_d   = wcnt_q;
      data_d   = data_q;
      we_d     = 1'b0;
      // The address steps once the registered write has gone out.
      addr_d   = we_q ? addr_q + 1'b1 : addr_q;

      if (bus_io.Start) begin
         state_d = GET_CNT_HI;
         xor_d   = '0;
         wcnt_d  = '0;
         addr_d  = '0;
      end else if (to_tc) begin
         state_d = ERR;
      end else if (bus_io.RxValid && is_get(state_q)) begin
         xor_d = xor_q ^ bus_io.RxData;
         case (state_q)
            GET_CNT_HI: begin
               cnt_hi_d = bus_io.RxData;
               state_d  = GET_CNT_LO;
            end
            GET_CNT_LO: begin
               n_d = n_rx;
               if (32'(n_rx) > DEPTH)  state_d = ERR;
               else if (n_rx == 16'd0) state_d = GET_CHK;
               else                    state_d = GET_HI;
            end
            GET_HI: begin
               hi_d    = bus_io.RxData;
               state_d = GET_LO;
            end
            GET_LO: begin
               data_d  = {hi_q, bus_io.RxData};
               we_d    = 1'b1;
               wcnt_d  = wcnt_inc;
               state_d = (32'(wcnt_inc) == 32'(n_q)) ? GET_CHK : GET_HI;
            end
            GET_CHK: begin
               // xor_q still excludes the checksum byte itself.
               state_d = (bus_io.RxData == xor_q) ? DONE : ERR;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         cnt_hi_q <= '0;
         n_q      <= '0;
         hi_q     <= '0;
         xor_q    <= '0;
         wcnt_q   <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_hi_q <= cnt_hi_d;
         n_q      <= n_d;
         hi_q     <= hi_d;
         xor_q    <= xor_d;
         wcnt_q   <= wcnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
      end
   end

   assign bus_io.MemAddr = addr_q;
   assign bus_io.MemData = data_q;
   assign bus_io.MemWe   = we_q;
   assign bus_io.CpuHold = is_get(state_q) || (state_q == ERR);
   assign bus_io.Done    = (state_q == DONE);
   assign bus_io.Error   = (state_q == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected RAM writes,
// a negedge monitor pops and compares them whenever MemWe is seen.
module tb_program_loader;

   localparam int AW      = 10;
   localparam int TIMEOUT = 20;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b1;

   program_loader_if #(.AW(AW)) bus ();

   program_loader #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus_io  (bus)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   logic [AW+15:0] exp_q[$];
   logic [AW+15:0] mon_e;
   logic [7:0]     frame[$];
   logic           prev_we = 1'b0;

   // Monitor: every write strobe must match the oldest expected {addr,data}.
   always @(negedge Clk) begin
      if (bus.MemWe === 1'b1) begin
         checks++;
         if (prev_we) begin
            errors++;
            $display("FAIL we_width actual=2+ cycles required=1 cycle addr=%h", bus.MemAddr);
         end
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual addr=%h data=%h required=no write",
                     bus.MemAddr, bus.MemData);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.MemAddr, bus.MemData} !== mon_e) begin
               errors++;
               $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                        bus.MemAddr, bus.MemData, mon_e[AW+15:16], mon_e[15:0]);
            end
         end
      end
      prev_we = bus.MemWe;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.RxValid = 1'b1;
      bus.RxData  = b;
      tick();
      bus.RxValid = 1'b0;
   endtask

   task automatic send_frame(input bit b2b);
      foreach (frame[i]) begin
         bus.RxValid = 1'b1;
         bus.RxData  = frame[i];
         tick();
         if (!b2b) begin
            bus.RxValid = 1'b0;
            tick();
         end
      end
      bus.RxValid = 1'b0;
   endtask

   task automatic start_load();
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      check("hold_after_start", 32'(bus.CpuHold), 32'd1);
   endtask

   task automatic push_word(input int addr, input logic [15:0] data);
      exp_q.push_back({AW'(addr), data});
   endtask

   task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
      check({tag, "_done"}, 32'(bus.Done), 32'(done));
      check({tag, "_error"}, 32'(bus.Error), 32'(err));
      check({tag, "_hold"}, 32'(bus.CpuHold), 32'(hold));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_addr"}, 32'(bus.MemAddr), 32'd0);
      check({tag, "_data"}, 32'(bus.MemData), 32'd0);
      check({tag, "_we"}, 32'(bus.MemWe), 32'd0);
      check_status(tag, 1'b0, 1'b0, 1'b0);
   endtask

   logic [7:0] x, hi, lo;

   initial begin
      bus.Start   = 1'b0;
      bus.RxValid = 1'b0;
      bus.RxData  = 8'h00;
      #2 Reset_n  = 1'b0;
      #10;
      check_outputs_zero("reset");
      tick();
      Reset_n = 1'b1;
      tick();

      // Normal three-word load with idle gaps between bytes.
      start_load();
      push_word(0, 16'h1234); push_word(1, 16'hABCD); push_word(2, 16'h0F0F);
      frame = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'h43};
      send_frame(1'b0);
      check_status("normal", 1'b1, 1'b0, 1'b0);
      check("normal_drained", 32'(exp_q.size()), 32'd0);
      check("normal_addr", 32'(bus.MemAddr), 32'd3);

      // Bad checksum: writes still happen, then error.
      start_load();
      check("restart_clears_done", 32'(bus.Done), 32'd0);
      push_word(0, 16'h1234); push_word(1, 16'hABCD); push_word(2, 16'h0F0F);
      frame = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'h44};
      send_frame(1'b0);
      check_status("badchk", 1'b0, 1'b1, 1'b1);
      check("badchk_drained", 32'(exp_q.size()), 32'd0);

      // Empty frame.
      start_load();
      frame = '{8'h00, 8'h00, 8'h00};
      send_frame(1'b0);
      check_status("empty", 1'b1, 1'b0, 1'b0);

      // Oversize count: 0x0401 words exceeds 1024.
      start_load();
      send_byte(8'h04);
      tick();
      send_byte(8'h01);
      check_status("oversize", 1'b0, 1'b1, 1'b1);
      send_byte(8'h12);
      send_byte(8'h34);
      tick();
      check("oversize_stays_err", 32'(bus.Error), 32'd1);

      // Timeout after the first HI byte.
      start_load();
      send_byte(8'h00); tick();
      send_byte(8'h02); tick();
      send_byte(8'h12);
      repeat (TIMEOUT - 1) tick();
      check("timeout_early", 32'(bus.Error), 32'd0);
      tick();
      check("timeout_error", 32'(bus.Error), 32'd1);
      check("timeout_hold", 32'(bus.CpuHold), 32'd1);

      // Restart mid-frame; the byte arriving with Start must be ignored.
      start_load();
      send_byte(8'h00); tick();
      send_byte(8'h05); tick();
      send_byte(8'hAA); tick();
      bus.Start   = 1'b1;
      bus.RxValid = 1'b1;
      bus.RxData  = 8'h77;
      tick();
      bus.Start   = 1'b0;
      bus.RxValid = 1'b0;
      push_word(0, 16'hBEEF);
      frame = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
      send_frame(1'b0);
      check_status("restart", 1'b1, 1'b0, 1'b0);
      check("restart_addr", 32'(bus.MemAddr), 32'd1);

      // Asynchronous reset while a write is pending drops the write.
      start_load();
      send_byte(8'h00); tick();
      send_byte(8'h02); tick();
      send_byte(8'h11); tick();
      send_byte(8'h22);
      #1 Reset_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      tick(); tick();
      Reset_n = 1'b1;
      send_byte(8'h33);
      send_byte(8'h44);
      tick();
      check_outputs_zero("after_reset");

      // Back-to-back bytes.
      start_load();
      push_word(0, 16'h1234); push_word(1, 16'hABCD); push_word(2, 16'h0F0F);
      frame = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'h43};
      send_frame(1'b1);
      tick();
      check_status("b2b", 1'b1, 1'b0, 1'b0);
      check("b2b_drained", 32'(exp_q.size()), 32'd0);

      // Full-depth load of 1024 words, back-to-back; address wraps to 0.
      start_load();
      frame = '{8'h04, 8'h00};
      x = 8'h04;
      for (int i = 0; i < 1024; i++) begin
         hi = 8'(i) ^ 8'h5A;
         lo = 8'(i >> 2) ^ 8'hC3;
         frame.push_back(hi);
         frame.push_back(lo);
         x = x ^ hi ^ lo;
         push_word(i, {hi, lo});
      end
      frame.push_back(x);
      send_frame(1'b1);
      tick();
      check_status("full", 1'b1, 1'b0, 1'b0);
      check("full_addr_wrap", 32'(bus.MemAddr), 32'd0);

      repeat (4) tick();
      check("final_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
